// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES ripple segments with a registered carry between segments.
// Define PIPE_ADD_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPE_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned SEG = WIDTH / STAGES;

   // Returns {carry out, carry into segment MSB, segment sum}.
   function automatic logic [SEG+1:0] ripple(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c0);
      logic           c;
      logic           cm;
      logic [SEG-1:0] s;
      c  = c0;
      cm = c0;
      s  = '0;
      for (int unsigned i = 0; i < SEG; i++) begin
         cm   = c;
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, cm, s};
   endfunction

   logic             vld_q   [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             c_q     [STAGES];

   logic             src_vld [STAGES];
   logic [WIDTH-1:0] src_a   [STAGES];
   logic [WIDTH-1:0] src_b   [STAGES];
   logic [WIDTH-1:0] src_sum [STAGES];
   logic             src_c   [STAGES];
   logic [WIDTH-1:0] nxt_sum [STAGES];
   logic             nxt_c   [STAGES];
   logic [SEG+1:0]   seg_r;
   logic             adv;

`ifdef PIPE_ADD_OVF_EN
   logic ovf_d;
   logic ovf_q;
   assign ovf = ovf_q;
`endif

   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;

   // Stage k sees the register of stage k-1; stage 0 sees the input port.
   always_comb begin
      src_vld[0] = in_valid;
      src_a[0]   = a;
      src_b[0]   = b;
      src_sum[0] = '0;
      src_c[0]   = cin;
      for (int unsigned k = 1; k < STAGES; k++) begin
         src_vld[k] = vld_q[k-1];
         src_a[k]   = a_q[k-1];
         src_b[k]   = b_q[k-1];
         src_sum[k] = sum_q[k-1];
         src_c[k]   = c_q[k-1];
      end
      seg_r = '0;
`ifdef PIPE_ADD_OVF_EN
      ovf_d = 1'b0;
`endif
      for (int unsigned k = 0; k < STAGES; k++) begin
         seg_r                    = ripple(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
         nxt_sum[k]               = src_sum[k];
         nxt_sum[k][k*SEG +: SEG] = seg_r[SEG-1:0];
         nxt_c[k]                 = seg_r[SEG+1];
`ifdef PIPE_ADD_OVF_EN
         ovf_d                    = seg_r[SEG+1] ^ seg_r[SEG];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            c_q[k]   <= 1'b0;
         end
`ifdef PIPE_ADD_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            vld_q[k] <= src_vld[k];
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            sum_q[k] <= nxt_sum[k];
            c_q[k]   <= nxt_c[k];
         end
`ifdef PIPE_ADD_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 32-bit/4-stage instance plus 8-bit/1-stage instance.
module tb_pipelined_adder;

   localparam int unsigned ST = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
   logic [31:0] a, b, sum;
`ifdef PIPE_ADD_OVF_EN
   logic        ovf;
`endif
   logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
   logic [7:0]  a8, b8, sum8;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(32), .STAGES(ST)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
`ifdef PIPE_ADD_OVF_EN
      , .ovf(ovf)
`endif
   );

   pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8)
`ifdef PIPE_ADD_OVF_EN
      , .ovf()
`endif
   );

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   logic [8:0]  q8[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned retired = 0;
   bit          chk_lat = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic c, input int unsigned cy);
      exp_t       e;
      logic [32:0] r;
      r     = {1'b0, x} + {1'b0, y} + {32'b0, c};
      e.s   = r[31:0];
      e.c   = r[32];
      e.o   = (x[31] == y[31]) && (r[31] != x[31]);
      e.cyc = cy;
      return e;
   endfunction

   // Drive one cycle at the falling edge, then score the handshakes of the coming rising edge.
   task automatic cycle(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic ordy);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      a         = av;
      b         = bv;
      cin       = ci;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_beat", 64'(out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            check("sum", 64'(sum), 64'(e.s));
            check("cout", 64'(cout), 64'(e.c));
`ifdef PIPE_ADD_OVF_EN
            check("ovf", 64'(ovf), 64'(e.o));
`endif
            if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(ST));
            retired++;
         end
      end
      if (in_valid && in_ready) q.push_back(model(av, bv, ci, cyc));
      cyc++;
   endtask

   task automatic beat(input logic [31:0] av, input logic [31:0] bv, input logic ci);
      cycle(1'b1, av, bv, ci, 1'b1);
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && q.size() != 0; i++) idle();
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_ADD_OVF_EN
      check("rst_ovf", 64'(ovf), 64'd0);
`endif
   endtask

   initial begin
      int unsigned r0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // Single beat latency and one-cycle output.
      chk_lat = 1'b1;
      beat(32'hFFFF_FFFF, 32'h0, 1'b1);
      repeat (ST - 1) begin
         idle();
         check("early_valid", 64'(out_valid), 64'd0);
      end
      idle();
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_retired", 64'(retired), 64'd1);
      idle();
      check("t1_one_cycle", 64'(out_valid), 64'd0);

      // Back-to-back beats.
      beat(32'h1234_5678, 32'h1111_1111, 1'b0);
      beat(32'h0000_FFFF, 32'h0000_0001, 1'b0);
      beat(32'h8000_0000, 32'h8000_0000, 1'b0);
      drain();

      // Backpressure with a full pipe.
      chk_lat = 1'b0;
      r0 = retired;
      for (int i = 0; i < 4; i++) beat($urandom, $urandom, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_valid", 64'(out_valid), 64'd1);
         if (q.size() != 0) check("stall_sum", 64'(sum), 64'(q[0].s));
      end
      drain();
      check("stall_count", 64'(retired - r0), 64'd4);
      repeat (3) idle();

      // Reset mid-stream.
      for (int i = 0; i < 3; i++) beat($urandom, $urandom, 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         idle();
         check("post_rst_valid", 64'(out_valid), 64'd0);
      end

`ifdef PIPE_ADD_OVF_EN
      beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      drain();
`endif

      // Random traffic with random bubbles and backpressure.
      for (int i = 0; i < 200; i++)
         cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      drain();

      // 8-bit single-stage instance.
      for (int i = 0; i <= 257; i++) begin
         logic [8:0] e8;
         @(negedge clk);
         in_valid8 = (i < 257);
         if (i == 0) begin
            a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
         end else begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
         end
         #1;
         if (i >= 1) check("lat8", 64'(out_valid8), 64'd1);
         if (out_valid8) begin
            if (q8.size() == 0) begin
               check("unexpected8", 64'(out_valid8), 64'd0);
            end else begin
               e8 = q8.pop_front();
               check("sum8", 64'({cout8, sum8}), 64'(e8));
            end
         end
         if (in_valid8 && in_ready8) q8.push_back({1'b0, a8} + {1'b0, b8} + {8'b0, cin8});
      end
      check("drain8_empty", 64'(q8.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got %0d checks expected completion", checks);
      $fatal(1);
   end

endmodule
